hazard_unit: RTL and testbench
==============================

# hazard_unit

Parametrised hazard detection and forwarding controller for the pipelined datapath. It compares the source register addresses of the instruction in ID against an internal shadow pipeline of in-flight destination writes in EX, MEM and WB. From that comparison it generates a load-use or no-forwarding stall and registered per-source forwarding selects for the EX stage. It sits between the decoder/ID latch and the EX operand muxes, and keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- REG_AW, 3, register address width (2^REG_AW architectural registers)
- FWD_EN, 1, 1 = forwarding enabled; 0 = every RAW match stalls and selects stay 0
- RF_BYPASS, 1, 1 = register file is write-before-read (a WB match is not a hazard); 0 = a WB match needs forward select 3, or a stall when FWD_EN=0
- ZERO_REG, 0, 1 = register 0 is hardwired and never matches
- CNT_W, 16, stall counter width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_src0, id_src1  in  REG_AW each  ID source addresses
- id_src_used  in  2  bit s = source s is actually read
- id_dest  in  REG_AW  ID destination address
- id_we  in  1  ID instruction writes a register
- id_is_load  in  1  ID instruction is a load (result valid only after MEM)
- flush  in  1  kill the ID instruction (branch taken)
- stall  out  1  hold PC and the ID latch this cycle (combinational)
- fwd_sel0, fwd_sel1  out  2 each  registered operand selects for the instruction now in EX: 0 RF, 1 EX/MEM latch, 2 MEM/WB latch, 3 WB latch
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- Shadow stages EX, MEM and WB each hold {v, we, ld, dest}.
- On every clock: WB<=MEM, MEM<=EX.
- EX<=bubble (v=0) if stall|flush|~id_valid; otherwise EX<={1, id_we, id_is_load, id_dest}.
- A stage matches source s when all of these hold:
  - id_valid and id_src_used[s];
  - stage v & we;
  - stage dest == src_s;
  - not (ZERO_REG and src_s == 0).
- stall = ~flush & id_valid & (H0 | H1). Hs for source s is true if any of:
  - EX matches with ld=1 (load-use);
  - FWD_EN=0 and EX or MEM matches;
  - FWD_EN=0 and RF_BYPASS=0 and WB matches.
- Forward selection for source s, computed when ID advances (no stall, no flush, id_valid). The youngest producer wins:
  - EX match -> 1;
  - else MEM match -> 2;
  - else WB match with RF_BYPASS=0 -> 3;
  - else 0.
  - All selects are forced to 0 when FWD_EN=0.
- fwd_selN is registered with the EX shadow and becomes 0 whenever a bubble enters EX.
- stall_cnt increments by 1 on each clock edge where stall=1 and saturates at 2^CNT_W-1.
- flush overrides stall; a flushed instruction never counts a stall cycle.

## Timing
- Reset (rst=1 at the edge):
  - all shadow v=0;
  - fwd_sel0 = fwd_sel1 = 0;
  - stall_cnt = 0;
  - stall is therefore 0 on the first cycle after reset.
- stall has zero latency: it is combinational from the ID inputs and the registered shadow state.
- fwd_sel has one cycle of latency: it is valid during the cycle the consumer occupies EX.
- A load-use pair with forwarding costs exactly 1 stall cycle; the consumer then gets fwd_sel=2.
- With FWD_EN=0, a back-to-back dependency stalls 2 cycles with RF_BYPASS=1, or 3 cycles with RF_BYPASS=0.
- rst asserted mid-stall clears everything at that edge; no state survives.
- flush and stall requested in the same cycle: flush wins, stall=0, a bubble enters EX, and the counter is unchanged.
- If both sources match the same producer, both selects take the same value; there is no extra stall.

## Test plan
- Reset: hold rst for 2 cycles with random inputs -> stall=0, fwd_sel0=fwd_sel1=0, stall_cnt=0 after release.
- ALU RAW, FWD_EN=1: issue "R3<=..." (we=1, ld=0), then the next cycle src0=3 -> no stall; fwd_sel0=1 in the consumer's EX cycle. With one unrelated instruction between them -> fwd_sel0=2.
- Load-use: load R5, then immediately src1=5 -> stall=1 for exactly 1 cycle; stall_cnt=1; the consumer's EX cycle has fwd_sel1=2.
- No forwarding: FWD_EN=0, RF_BYPASS=0; write R2, then read R2 -> stall high 3 cycles; fwd_sel stays 0; stall_cnt=3.
- ZERO_REG=1: write R0, then read R0 -> no stall, fwd_sel0=0. Same test with ZERO_REG=0 -> fwd_sel0=1.
- Flush and saturation:
  - assert flush during a load-use stall -> stall=0 and EX receives a bubble;
  - with CNT_W=2, force 5 stall cycles -> stall_cnt holds at 3.

Source files
------------

// File: rtl/hazard_unit_if.sv
// ID-stage hazard bundle: decoder-side request fields and the unit's
// stall / forward-select / performance outputs.
interface hazard_unit_if #(
    parameter int unsigned REG_AW = 3,
    parameter int unsigned CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_src0;
    logic [REG_AW-1:0] id_src1;
    logic [1:0]        id_src_used;
    logic [REG_AW-1:0] id_dest;
    logic              id_we;
    logic              id_is_load;
    logic              flush;
    logic              stall;
    logic [1:0]        fwd_sel0;
    logic [1:0]        fwd_sel1;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_src0, id_src1, id_src_used, id_dest, id_we, id_is_load, flush,
        input  stall, fwd_sel0, fwd_sel1, stall_cnt
    );

    modport slave (
        input  id_valid, id_src0, id_src1, id_src_used, id_dest, id_we, id_is_load, flush,
        output stall, fwd_sel0, fwd_sel1, stall_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// Hazard detection and EX operand forwarding control, tracking in-flight
// destination writes in a shadow EX/MEM/WB pipeline.
module hazard_unit #(
    parameter int unsigned REG_AW    = 3,
    parameter int unsigned FWD_EN    = 1,
    parameter int unsigned RF_BYPASS = 1,
    parameter int unsigned ZERO_REG  = 0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_unit_if.slave  hz
);
    localparam logic FWD_ON = (FWD_EN != 0);
    localparam logic BYP_ON = (RF_BYPASS != 0);
    localparam logic ZR_ON  = (ZERO_REG != 0);

    typedef struct packed {
        logic              v;
        logic              we;
        logic              ld;
        logic [REG_AW-1:0] dest;
    } stage_t;

    stage_t           ex_q, mem_q, wb_q, ex_d;
    logic [1:0]       fwd0_q, fwd1_q, fwd0_d, fwd1_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [REG_AW-1:0] src [2];
    logic [1:0]        rd, m_ex, m_mem, m_wb, haz;
    logic [1:0]        sel [2];
    logic              stall_c, advance;

    function automatic logic src_match(stage_t st, logic rd_en, logic [REG_AW-1:0] a);
        return rd_en & st.v & st.we & (st.dest == a) & ~(ZR_ON & (a == '0));
    endfunction

    // Per-source matches, hazard decision and youngest-producer select
    always_comb begin
        src[0]  = hz.id_src0;
        src[1]  = hz.id_src1;
        rd      = {2{hz.id_valid}} & hz.id_src_used;
        m_ex    = '0;
        m_mem   = '0;
        m_wb    = '0;
        haz     = '0;
        sel[0]  = 2'd0;
        sel[1]  = 2'd0;
        for (int s = 0; s < 2; s++) begin
            m_ex[s]  = src_match(ex_q,  rd[s], src[s]);
            m_mem[s] = src_match(mem_q, rd[s], src[s]);
            m_wb[s]  = src_match(wb_q,  rd[s], src[s]);
            haz[s]   = (m_ex[s] & ex_q.ld)
                     | (~FWD_ON & (m_ex[s] | m_mem[s]))
                     | (~FWD_ON & ~BYP_ON & m_wb[s]);
            if (FWD_ON) begin
                if (m_ex[s])                 sel[s] = 2'd1;
                else if (m_mem[s])           sel[s] = 2'd2;
                else if (m_wb[s] && !BYP_ON) sel[s] = 2'd3;
            end
        end
        stall_c = ~hz.flush & hz.id_valid & (|haz);
        advance = hz.id_valid & ~stall_c & ~hz.flush;
    end

    // Next EX shadow entry, registered selects and saturating counter
    always_comb begin
        ex_d   = '0;
        fwd0_d = 2'd0;
        fwd1_d = 2'd0;
        cnt_d  = cnt_q;
        if (advance) begin
            ex_d.v    = 1'b1;
            ex_d.we   = hz.id_we;
            ex_d.ld   = hz.id_is_load;
            ex_d.dest = hz.id_dest;
            fwd0_d    = sel[0];
            fwd1_d    = sel[1];
        end
        if (stall_c && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q   <= '0;
            mem_q  <= '0;
            wb_q   <= '0;
            fwd0_q <= 2'd0;
            fwd1_q <= 2'd0;
            cnt_q  <= '0;
        end else begin
            ex_q   <= ex_d;
            mem_q  <= ex_q;
            wb_q   <= mem_q;
            fwd0_q <= fwd0_d;
            fwd1_q <= fwd1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign hz.stall     = stall_c;
    assign hz.fwd_sel0  = fwd0_q;
    assign hz.fwd_sel1  = fwd1_q;
    assign hz.stall_cnt = cnt_q;
endmodule

// File: tb/tb_hazard_unit.sv
// Four hazard_unit configurations driven by one instruction stream and
// checked against an age-based model of in-flight producers.
module tb_hazard_unit;
    // inst0: fwd, no bypass | inst1: no fwd, no bypass, zero reg, 2-bit cnt
    // inst2: no fwd, bypass | inst3: fwd, bypass, zero reg
    localparam logic [3:0] CFG_FWD = 4'b1001;
    localparam logic [3:0] CFG_BYP = 4'b1100;
    localparam logic [3:0] CFG_ZR  = 4'b1010;

    typedef struct packed { bit v; bit we; bit ld; bit [2:0] dest; } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid = 1'b0, in_we = 1'b0, in_ld = 1'b0, in_flush = 1'b0;
    logic [2:0] in_s0 = '0, in_s1 = '0, in_dest = '0;
    logic [1:0] in_used = '0;

    hazard_unit_if #(.REG_AW(3), .CNT_W(16)) if0 ();
    hazard_unit_if #(.REG_AW(3), .CNT_W(2))  if1 ();
    hazard_unit_if #(.REG_AW(3), .CNT_W(16)) if2 ();
    hazard_unit_if #(.REG_AW(3), .CNT_W(16)) if3 ();

    assign if0.id_valid = in_valid; assign if0.id_src0 = in_s0; assign if0.id_src1 = in_s1;
    assign if0.id_src_used = in_used; assign if0.id_dest = in_dest; assign if0.id_we = in_we;
    assign if0.id_is_load = in_ld; assign if0.flush = in_flush;
    assign if1.id_valid = in_valid; assign if1.id_src0 = in_s0; assign if1.id_src1 = in_s1;
    assign if1.id_src_used = in_used; assign if1.id_dest = in_dest; assign if1.id_we = in_we;
    assign if1.id_is_load = in_ld; assign if1.flush = in_flush;
    assign if2.id_valid = in_valid; assign if2.id_src0 = in_s0; assign if2.id_src1 = in_s1;
    assign if2.id_src_used = in_used; assign if2.id_dest = in_dest; assign if2.id_we = in_we;
    assign if2.id_is_load = in_ld; assign if2.flush = in_flush;
    assign if3.id_valid = in_valid; assign if3.id_src0 = in_s0; assign if3.id_src1 = in_s1;
    assign if3.id_src_used = in_used; assign if3.id_dest = in_dest; assign if3.id_we = in_we;
    assign if3.id_is_load = in_ld; assign if3.flush = in_flush;

    hazard_unit #(.REG_AW(3), .FWD_EN(1), .RF_BYPASS(0), .ZERO_REG(0), .CNT_W(16))
        u0 (.clk(clk), .rst(rst), .hz(if0));
    hazard_unit #(.REG_AW(3), .FWD_EN(0), .RF_BYPASS(0), .ZERO_REG(1), .CNT_W(2))
        u1 (.clk(clk), .rst(rst), .hz(if1));
    hazard_unit #(.REG_AW(3), .FWD_EN(0), .RF_BYPASS(1), .ZERO_REG(0), .CNT_W(16))
        u2 (.clk(clk), .rst(rst), .hz(if2));
    hazard_unit #(.REG_AW(3), .FWD_EN(1), .RF_BYPASS(1), .ZERO_REG(1), .CNT_W(16))
        u3 (.clk(clk), .rst(rst), .hz(if3));

    logic        act_stall [4];
    logic [1:0]  act_f0 [4];
    logic [1:0]  act_f1 [4];
    logic [31:0] act_cnt [4];
    assign act_stall[0] = if0.stall; assign act_f0[0] = if0.fwd_sel0; assign act_f1[0] = if0.fwd_sel1;
    assign act_stall[1] = if1.stall; assign act_f0[1] = if1.fwd_sel0; assign act_f1[1] = if1.fwd_sel1;
    assign act_stall[2] = if2.stall; assign act_f0[2] = if2.fwd_sel0; assign act_f1[2] = if2.fwd_sel1;
    assign act_stall[3] = if3.stall; assign act_f0[3] = if3.fwd_sel0; assign act_f1[3] = if3.fwd_sel1;
    assign act_cnt[0] = 32'(if0.stall_cnt);
    assign act_cnt[1] = 32'(if1.stall_cnt);
    assign act_cnt[2] = 32'(if2.stall_cnt);
    assign act_cnt[3] = 32'(if3.stall_cnt);

    // Model: slot[k][a] is the producer issued a+1 cycles ago (youngest first)
    ent_t slot [4][3];
    int   exp_f0 [4], exp_f1 [4], exp_cnt [4], cnt_max [4], stall_seen [4];
    bit   es [4];
    int   total = 0, bad = 0;

    task automatic chk(input string tag, input longint obs, input longint exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic int age_of(int k, bit used, bit [2:0] src);
        if (!in_valid || !used) return 0;
        if (CFG_ZR[k] && src == 3'd0) return 0;
        for (int a = 0; a < 3; a++)
            if (slot[k][a].v && slot[k][a].we && slot[k][a].dest == src) return a + 1;
        return 0;
    endfunction

    function automatic bit src_hazard(int k, int d);
        if (d == 1 && slot[k][0].ld) return 1'b1;
        if (!CFG_FWD[k] && d != 0 && (d < 3 || !CFG_BYP[k])) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int sel_of(int k, int d);
        if (!CFG_FWD[k]) return 0;
        if (d == 3 && CFG_BYP[k]) return 0;
        return d;
    endfunction

    function automatic bit stall_exp(int k);
        return !in_flush && in_valid &&
               (src_hazard(k, age_of(k, in_used[0], in_s0)) || src_hazard(k, age_of(k, in_used[1], in_s1)));
    endfunction

    task automatic cycle(input bit r, input bit chk_en, input bit v, input bit [2:0] s0, input bit [2:0] s1,
                         input bit [1:0] used, input bit [2:0] dest, input bit we, input bit ld, input bit fl);
        int nf0, nf1;
        bit adv;
        rst = r; in_valid = v; in_s0 = s0; in_s1 = s1; in_used = used;
        in_dest = dest; in_we = we; in_ld = ld; in_flush = fl;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            es[k] = stall_exp(k);
            if (act_stall[k]) stall_seen[k]++;
            if (chk_en) begin
                chk($sformatf("stall[%0d]", k), act_stall[k], es[k]);
                chk($sformatf("fwd0[%0d]", k), act_f0[k], exp_f0[k]);
                chk($sformatf("fwd1[%0d]", k), act_f1[k], exp_f1[k]);
                chk($sformatf("cnt[%0d]", k), act_cnt[k], exp_cnt[k]);
            end
        end
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (r) begin
                for (int a = 0; a < 3; a++) slot[k][a] = '0;
                exp_f0[k] = 0; exp_f1[k] = 0; exp_cnt[k] = 0;
            end else begin
                if (es[k] && exp_cnt[k] < cnt_max[k]) exp_cnt[k]++;
                adv = in_valid && !es[k] && !in_flush;
                nf0 = adv ? sel_of(k, age_of(k, in_used[0], in_s0)) : 0;
                nf1 = adv ? sel_of(k, age_of(k, in_used[1], in_s1)) : 0;
                slot[k][2] = slot[k][1];
                slot[k][1] = slot[k][0];
                slot[k][0] = adv ? ent_t'{1'b1, in_we, in_ld, in_dest} : ent_t'('0);
                exp_f0[k] = nf0; exp_f1[k] = nf1;
            end
        end
        #1;
    endtask

    task automatic issue(input bit v, input bit [2:0] s0, input bit [2:0] s1, input bit [1:0] used,
                         input bit [2:0] dest, input bit we, input bit ld, input bit fl);
        cycle(1'b0, 1'b1, v, s0, s1, used, dest, we, ld, fl);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++)
            cycle(1'b1, 1'b0, 1'($urandom), 3'($urandom), 3'($urandom), 2'($urandom),
                  3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        for (int k = 0; k < 4; k++) stall_seen[k] = 0;
    endtask

    initial begin
        cnt_max[0] = 65535; cnt_max[1] = 3; cnt_max[2] = 65535; cnt_max[3] = 65535;

        do_reset();
        rst = 1'b0; in_valid = 1'b0; in_flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst_stall[%0d]", k), act_stall[k], 0);
            chk($sformatf("rst_f0[%0d]", k), act_f0[k], 0);
            chk($sformatf("rst_f1[%0d]", k), act_f1[k], 0);
            chk($sformatf("rst_cnt[%0d]", k), act_cnt[k], 0);
        end

        // ALU RAW back-to-back, then with one unrelated instruction between
        issue(1, 0, 0, 2'b00, 3, 1, 0, 0);
        issue(1, 3, 0, 2'b01, 1, 0, 0, 0);
        chk("alu_raw_sel1", act_f0[0], 1);
        do_reset();
        issue(1, 0, 0, 2'b00, 3, 1, 0, 0);
        issue(1, 0, 0, 2'b00, 6, 1, 0, 0);
        issue(1, 3, 0, 2'b01, 1, 0, 0, 0);
        chk("alu_gap_sel2", act_f0[0], 2);

        // Load-use: one stall, then MEM/WB forward
        do_reset();
        issue(1, 0, 0, 2'b00, 5, 1, 1, 0);
        issue(1, 0, 5, 2'b10, 1, 0, 0, 0);
        issue(1, 0, 5, 2'b10, 1, 0, 0, 0);
        chk("lu_sel2", act_f1[0], 2);
        chk("lu_cnt", act_cnt[0], 1);
        chk("lu_stalls", stall_seen[0], 1);

        // No forwarding: 3 stalls without bypass, 2 with
        do_reset();
        issue(1, 0, 0, 2'b00, 2, 1, 0, 0);
        for (int i = 0; i < 4; i++) issue(1, 2, 0, 2'b01, 1, 0, 0, 0);
        chk("nofwd_stalls", stall_seen[1], 3);
        chk("nofwd_cnt", act_cnt[1], 3);
        chk("nofwd_sel", act_f0[1], 0);
        chk("nofwd_byp_stalls", stall_seen[2], 2);

        // Register zero
        do_reset();
        issue(1, 0, 0, 2'b00, 0, 1, 0, 0);
        issue(1, 0, 0, 2'b01, 1, 0, 0, 0);
        chk("r0_nozr_sel", act_f0[0], 1);
        chk("r0_zr_sel", act_f0[3], 0);
        chk("r0_zr_stalls", stall_seen[3] + stall_seen[1], 0);

        // Flush during a load-use stall
        do_reset();
        issue(1, 0, 0, 2'b00, 5, 1, 1, 0);
        issue(1, 0, 5, 2'b10, 1, 0, 0, 1);
        chk("flush_stalls", stall_seen[0], 0);
        chk("flush_sel", act_f1[0], 0);
        chk("flush_cnt", act_cnt[0], 0);

        // Saturation of the 2-bit counter with a repeated self-dependency
        do_reset();
        for (int i = 0; i < 10; i++) issue(1, 2, 0, 2'b01, 2, 1, 0, 0);
        chk("sat_enough", (stall_seen[1] >= 5) ? 1 : 0, 1);
        chk("sat_cnt", act_cnt[1], 3);

        // Random stream with occasional mid-run resets
        for (int i = 0; i < 800; i++)
            cycle(($urandom_range(0, 63) == 0), 1'b1, ($urandom_range(0, 7) != 0),
                  3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 2'($urandom),
                  3'($urandom_range(0, 3)), 1'($urandom), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
